i2c24_rcv: RTL
==============

I2C24_RCV -- requirements
Module: i2c24_rcv

Interface
REQ-001 Parameter SLV_ADDR, default 7'h1A, is the 7-bit target address this block answers to (8-bit write address 8'h34).
REQ-002 clk  input  1  system clock; all internal state is clocked on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 SCL  input  1  I2C clock, driven by the master.
REQ-005 SDA  inout  1  I2C data, open-drain: the block drives 1'b0 or 1'bz only, and an external pull-up supplies the high level.
REQ-006 data16  output  16  last complete data word received, high byte first.
REQ-007 rdy  output  1  one-clk pulse when data16 updates.
REQ-008 busy  output  1  high from an accepted START until the frame ends.

Function
REQ-009 SCL and SDA are each double-flopped to clk, with a third flop for edge detection; all decisions use only the synchronized versions.
REQ-010 Correct operation requires the clk frequency to be at least 8x the SCL frequency.
REQ-011 START is detected as a synchronized SDA fall while SCL is high.
REQ-012 STOP is detected as a synchronized SDA rise while SCL is high.
REQ-013 Bits are sampled on the synchronized SCL rising edge and shifted in MSB first.
REQ-014 The state machine has the states IDLE, ADDR, ACK_A, BYTE_H, ACK_H, BYTE_L, ACK_L, WAIT_P.
REQ-015 IDLE -> ADDR on START, with the bit counter cleared.
REQ-016 ADDR: after 8 bits, if the byte equals {SLV_ADDR,1'b0} -> ACK_A; otherwise (address mismatch or R/W=1) -> WAIT_P with no ACK.
REQ-017 ACK_x: SDA is driven low starting at the SCL falling edge after bit 8 and released at the next SCL falling edge.
REQ-018 From ACK_x the machine advances: ACK_A -> BYTE_H, ACK_H -> BYTE_L, ACK_L -> WAIT_P.
REQ-019 BYTE_H and BYTE_L each shift in 8 bits into a 16-bit shift register that is separate from data16.
REQ-020 WAIT_P ignores SCL and SDA, except for STOP and START.
REQ-021 A STOP in WAIT_P reached via ACK_L loads data16 from the shift register, pulses rdy for exactly one clk, and -> IDLE.
REQ-022 A STOP in any other non-IDLE state -> IDLE; data16 holds its previous value and no rdy pulse occurs.
REQ-023 A START (repeated start) in any non-IDLE state -> ADDR, with the bit counter and shift register cleared and no rdy pulse.
REQ-024 A frame contains a maximum of 2 data bytes; any SCL activity after ACK_L is ignored until STOP or START.
REQ-025 busy = (state != IDLE).
REQ-026 SDA is released (z) in every state except during the ACK window.

Reset
REQ-027 When rst_n=0, the block asynchronously goes to: state IDLE, data16=16'h0000, rdy=0, busy=0, SDA=z, all counters and shifters 0.
REQ-028 The synchronizer flops reset to 1 (bus idle level) so that reset release creates no false START or STOP.
REQ-029 A reset mid-frame immediately releases SDA; after reset release the block waits for a fresh START.

Verification
REQ-030 Valid write START, 8'h34, 8'h0C, 8'h0F, STOP -> SDA is low on all 3 ACK bits, data16=16'h0C0F, and rdy is high for exactly 1 clk after STOP.
REQ-031 Wrong address START, 8'h36, 8'hAA, 8'h55, STOP -> SDA is never driven low, rdy stays 0, and data16 is unchanged.
REQ-032 Read request START, 8'h35, ... STOP -> NAK on the address byte, and no rdy.
REQ-033 Aborted frame START, 8'h34, 8'h12, STOP -> 2 ACKs, no rdy, data16 keeps its prior value (16'h0C0F), busy=0 after STOP.
REQ-034 Repeated start START, 8'h34, 8'h12, START, 8'h34, 8'hBE, 8'hEF, STOP -> data16=16'hBEEF, and rdy pulses once.
REQ-035 Reset during ACK: assert rst_n=0 while SDA is held low in ACK_H -> SDA=z within the same cycle, and state IDLE, busy=0, data16=0.

Source files
------------

// File: rtl/i2c24_rcv.sv
// Write-only I2C target that receives a two-byte word (high byte first) and
// presents it on data16 with a single-clk rdy strobe once the frame's STOP arrives.
module i2c24_rcv #(
  parameter logic [6:0] SLV_ADDR = 7'h1A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SCL,
  inout  wire         SDA,
  output logic [15:0] data16,
  output logic        rdy,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ACK_A, BYTE_H, ACK_H, BYTE_L, ACK_L, WAIT_P
  } state_e;

  // [0],[1] synchronize; [2] is the previous synchronized value for edge detection.
  logic [2:0] scl_q, sda_q;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [6:0]  addr_q, addr_d;
  logic [15:0] shift_q, shift_d;
  logic        ack_drv_q, ack_drv_d;
  logic        frame_ok_q, frame_ok_d;
  logic [15:0] data16_q, data16_d;
  logic        rdy_q, rdy_d;

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  assign scl_s     = scl_q[1];
  assign sda_s     = sda_q[1];
  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  assign start_det = scl_s & ~sda_q[1] & sda_q[2];
  assign stop_det  = scl_s & sda_q[1] & ~sda_q[2];

  // Idle-high reset level keeps reset release from looking like a START or STOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], SCL};
      sda_q <= {sda_q[1:0], SDA};
    end
  end

  always_comb begin
    // NOTE: every next-state variable gets its hold value first so no path
    // through the case statement can leave one unassigned (which would infer a latch).
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    shift_d    = shift_q;
    ack_drv_d  = ack_drv_q;
    frame_ok_d = frame_ok_q;
    data16_d   = data16_q;
    rdy_d      = 1'b0;

    if (start_det) begin
      state_d    = ADDR;
      cnt_d      = '0;
      addr_d     = '0;
      shift_d    = '0;
      ack_drv_d  = 1'b0;
      frame_ok_d = 1'b0;
    end else if (stop_det && state_q != IDLE) begin
      if (state_q == WAIT_P && frame_ok_q) begin
        data16_d = shift_q;
        rdy_d    = 1'b1;
      end
      state_d    = IDLE;
      cnt_d      = '0;
      ack_drv_d  = 1'b0;
      frame_ok_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, WAIT_P: ;
        ADDR: if (scl_rise) begin
          addr_d = {addr_q[5:0], sda_s};
          cnt_d  = cnt_q + 3'd1;
          if (cnt_q == 3'd7)
            state_d = ({addr_q, sda_s} == {SLV_ADDR, 1'b0}) ? ACK_A : WAIT_P;
        end
        BYTE_H, BYTE_L: if (scl_rise) begin
          shift_d = {shift_q[14:0], sda_s};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7)
            state_d = (state_q == BYTE_H) ? ACK_H : ACK_L;
        end
        // First SCL fall after bit 8 opens the ACK window, the next one closes it.
        ACK_A, ACK_H, ACK_L: if (scl_fall) begin
          if (!ack_drv_q) begin
            ack_drv_d = 1'b1;
          end else begin
            ack_drv_d  = 1'b0;
            cnt_d      = '0;
            frame_ok_d = (state_q == ACK_L);
            state_d    = (state_q == ACK_A) ? BYTE_H :
                         (state_q == ACK_H) ? BYTE_L : WAIT_P;
          end
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; all registers here are plain flops and all are reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      shift_q    <= '0;
      ack_drv_q  <= 1'b0;
      frame_ok_q <= 1'b0;
      data16_q   <= '0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      shift_q    <= shift_d;
      ack_drv_q  <= ack_drv_d;
      frame_ok_q <= frame_ok_d;
      data16_q   <= data16_d;
      rdy_q      <= rdy_d;
    end
  end

  assign SDA    = ack_drv_q ? 1'b0 : 1'bz;
  assign data16 = data16_q;
  assign rdy    = rdy_q;
  assign busy   = (state_q != IDLE);

endmodule
